// File: rtl/pwm_fader_if.sv
// pwm_fader_if: target-write port of the RGB level fader.
// The master side (software or encoder logic) drives a channel
// select and a target level; the fader answers with cfg_ready.
interface pwm_fader_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_chan;
    logic [WIDTH-1:0] cfg_target;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_target,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_target,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_fader.sv
// pwm_fader: walks the R, G and B PWM levels one LSB at a time toward
// per-channel targets, paced by a programmable prescaler, so colour
// changes ramp smoothly.
// Optional feature macro PWM_FADER_BROADCAST_EN: when defined, a write
// to channel 3 loads all three targets at once; when undefined such a
// write changes nothing and pulses cfg_err for one cycle.
module pwm_fader #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_fader_if.slave           cfg,
    input  logic [DIV_WIDTH-1:0] step_div,
    output logic [WIDTH-1:0]     level_r,
    output logic [WIDTH-1:0]     level_g,
    output logic [WIDTH-1:0]     level_b,
    output logic [2:0]           busy,
    output logic [2:0]           done,
    output logic                 cfg_err
);

    // Per-channel ramp direction, derived from level vs target each cycle
    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } dir_t;

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic                 tick;
    logic                 accept;

    logic [WIDTH-1:0]     level_q  [3];
    logic [WIDTH-1:0]     level_d  [3];
    logic [WIDTH-1:0]     target_q [3];
    logic [WIDTH-1:0]     target_d [3];
    dir_t                 dir      [3];

    logic [2:0]           busy_q;
    logic [2:0]           busy_d;
    logic [2:0]           done_q;
    logic [2:0]           done_d;

    // No backpressure: the port is ready whenever we are out of reset
    assign cfg.cfg_ready = !reset;
    assign accept        = cfg.cfg_valid && !reset;

    // Prescaler: tick when the count reaches step_div, so a lowered
    // step_div that is already passed still ticks on the next cycle
    always_comb begin
        tick  = (cnt_q >= step_div);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Target registers take a write on the edge it is accepted
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            target_d[n] = target_q[n];
        end
        if (accept) begin
            for (int n = 0; n < 3; n++) begin
                if (cfg.cfg_chan == 2'(n)) begin
                    target_d[n] = cfg.cfg_target;
                end
            end
`ifdef PWM_FADER_BROADCAST_EN
            if (cfg.cfg_chan == 2'd3) begin
                for (int n = 0; n < 3; n++) begin
                    target_d[n] = cfg.cfg_target;
                end
            end
`endif
        end
    end

    // Step each channel toward its old target on a tick; since a step is
    // a single LSB toward the target it always lands on it and never wraps
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            level_d[n] = level_q[n];
            if (level_q[n] == target_q[n]) begin
                dir[n] = IDLE;
            end else if (level_q[n] < target_q[n]) begin
                dir[n] = UP;
            end else begin
                dir[n] = DOWN;
            end
            if (tick) begin
                case (dir[n])
                    UP:      level_d[n] = level_q[n] + 1'b1;
                    DOWN:    level_d[n] = level_q[n] - 1'b1;
                    default: level_d[n] = level_q[n];
                endcase
            end
            done_d[n] = tick && (dir[n] != IDLE) && (level_d[n] == target_d[n]);
            busy_d[n] = (level_d[n] != target_d[n]);
        end
    end

    // State register for prescaler, levels, targets and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            for (int n = 0; n < 3; n++) begin
                level_q[n]  <= '0;
                target_q[n] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            for (int n = 0; n < 3; n++) begin
                level_q[n]  <= level_d[n];
                target_q[n] <= target_d[n];
            end
        end
    end

`ifdef PWM_FADER_BROADCAST_EN
    assign cfg_err = 1'b0;
`else
    logic err_q;

    // Flag a write to the unimplemented broadcast channel for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (cfg.cfg_chan == 2'd3);
        end
    end

    assign cfg_err = err_q;
`endif

    assign level_r = level_q[0];
    assign level_g = level_q[1];
    assign level_b = level_q[2];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: self-checking bench for pwm_fader (default build or
// with PWM_FADER_BROADCAST_EN defined).
module tb_pwm_fader;

    localparam int W  = 8;
    localparam int DW = 16;
`ifdef PWM_FADER_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] stepDiv;
    logic [W-1:0]  levelR;
    logic [W-1:0]  levelG;
    logic [W-1:0]  levelB;
    logic [2:0]    busy;
    logic [2:0]    done;
    logic          cfgErr;

    pwm_fader_if #(.WIDTH(W)) cfgBus ();

    pwm_fader #(
        .WIDTH     (W),
        .DIV_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg      (cfgBus),
        .step_div (stepDiv),
        .level_r  (levelR),
        .level_g  (levelG),
        .level_b  (levelB),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfgErr)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural reference state
    int   mLevel  [3] = '{0, 0, 0};
    int   mTarget [3] = '{0, 0, 0};
    int   mCnt        = 0;
    int   mBusy       = 0;
    int   mDone       = 0;
    int   mErr        = 0;

    // Observation counters for multi-cycle sequences
    int   trackDone [3];
    int   trackJump [3];
    int   lastLevel [3];
    int   trackErr;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] chan;
        logic [7:0] target;
        int         expR;
        int         expG;
        int         expB;
        int         expBusy;
        int         expDone;
        int         expReady;
    } vec_t;

    vec_t vecs [10];

    function automatic int levelOf(input int ch);
        case (ch)
            0:       return int'(levelR);
            1:       return int'(levelG);
            default: return int'(levelB);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: one tick moves every unfinished channel one LSB toward
    // the target it had before this edge's write
    task automatic modelEdge();
        int  oldT [3];
        bit  tick;
        int  ch;
        bit  moved;
        if (reset) begin
            mLevel  = '{0, 0, 0};
            mTarget = '{0, 0, 0};
            mCnt    = 0;
            mBusy   = 0;
            mDone   = 0;
            mErr    = 0;
        end else begin
            tick = (mCnt >= int'(stepDiv));
            mCnt = tick ? 0 : mCnt + 1;
            oldT = mTarget;
            mErr = 0;
            if (cfgBus.cfg_valid) begin
                ch = int'(cfgBus.cfg_chan);
                if (ch < 3) begin
                    mTarget[ch] = int'(cfgBus.cfg_target);
                end else if (BCAST) begin
                    mTarget = '{int'(cfgBus.cfg_target), int'(cfgBus.cfg_target), int'(cfgBus.cfg_target)};
                end else begin
                    mErr = 1;
                end
            end
            mBusy = 0;
            mDone = 0;
            for (int n = 0; n < 3; n++) begin
                moved = 1'b0;
                if (tick && mLevel[n] != oldT[n]) begin
                    mLevel[n] = mLevel[n] + ((oldT[n] > mLevel[n]) ? 1 : -1);
                    moved = 1'b1;
                end
                if (moved && mLevel[n] == mTarget[n]) mDone = mDone | (1 << n);
                if (mLevel[n] != mTarget[n])           mBusy = mBusy | (1 << n);
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("level_r",   int'(levelR),           mLevel[0]);
        checkOutput("level_g",   int'(levelG),           mLevel[1]);
        checkOutput("level_b",   int'(levelB),           mLevel[2]);
        checkOutput("busy",      int'(busy),             mBusy);
        checkOutput("done",      int'(done),             mDone);
        checkOutput("cfg_err",   int'(cfgErr),           mErr);
        checkOutput("cfg_ready", int'(cfgBus.cfg_ready), reset ? 0 : 1);
    endtask

    task automatic clearTrack();
        for (int n = 0; n < 3; n++) begin
            trackDone[n] = 0;
            trackJump[n] = 0;
            lastLevel[n] = levelOf(n);
        end
        trackErr = 0;
    endtask

    // Drive one cycle of inputs, advance the reference, then compare
    task automatic applyStimulus(input logic rst, input logic valid,
                                 input logic [1:0] chan, input logic [7:0] target);
        int cur;
        reset             = rst;
        cfgBus.cfg_valid  = valid;
        cfgBus.cfg_chan   = chan;
        cfgBus.cfg_target = target;
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
        for (int n = 0; n < 3; n++) begin
            cur = levelOf(n);
            if (cur - lastLevel[n] > 1 || lastLevel[n] - cur > 1) trackJump[n]++;
            lastLevel[n] = cur;
            trackDone[n] += int'(done[n]);
        end
        trackErr += int'(cfgErr);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic waitLevel(input int ch, input int value, input int budget);
        int found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (levelOf(ch) == value) begin
                found = 1;
                break;
            end
            idle(1);
        end
        checkOutput($sformatf("reach ch%0d=%0d", ch, value), found, 1);
    endtask

    initial begin
        int t1;
        int t2;
        int r;

        reset             = 1'b1;
        stepDiv           = '0;
        cfgBus.cfg_valid  = 1'b0;
        cfgBus.cfg_chan   = 2'd0;
        cfgBus.cfg_target = 8'd0;
        clearTrack();

        // rst valid chan tgt   R  G  B  busy done ready
        vecs[0] = '{1'b1, 1'b0, 2'd0, 8'd0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1'b0, 1'b1, 2'd0, 8'd5, 0, 0, 0, 1, 0, 1};
        vecs[2] = '{1'b0, 1'b0, 2'd0, 8'd0, 1, 0, 0, 1, 0, 1};
        vecs[3] = '{1'b0, 1'b0, 2'd0, 8'd0, 2, 0, 0, 1, 0, 1};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 8'd0, 3, 0, 0, 1, 0, 1};
        vecs[5] = '{1'b0, 1'b0, 2'd0, 8'd0, 4, 0, 0, 1, 0, 1};
        vecs[6] = '{1'b0, 1'b0, 2'd0, 8'd0, 5, 0, 0, 0, 1, 1};
        vecs[7] = '{1'b0, 1'b0, 2'd0, 8'd0, 5, 0, 0, 0, 0, 1};
        vecs[8] = '{1'b0, 1'b1, 2'd0, 8'd5, 5, 0, 0, 0, 0, 1};
        vecs[9] = '{1'b0, 1'b0, 2'd0, 8'd0, 5, 0, 0, 0, 0, 1};

        $display("[TB] table vectors, step_div=0");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].chan, vecs[i].target);
            checkOutput($sformatf("vec%0d level_r", i), int'(levelR), vecs[i].expR);
            checkOutput($sformatf("vec%0d level_g", i), int'(levelG), vecs[i].expG);
            checkOutput($sformatf("vec%0d level_b", i), int'(levelB), vecs[i].expB);
            checkOutput($sformatf("vec%0d busy", i),    int'(busy),   vecs[i].expBusy);
            checkOutput($sformatf("vec%0d done", i),    int'(done),   vecs[i].expDone);
            checkOutput($sformatf("vec%0d ready", i),   int'(cfgBus.cfg_ready), vecs[i].expReady);
        end

        $display("[TB] step_div=3 pacing on G");
        stepDiv = 16'd3;
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        applyStimulus(1'b0, 1'b1, 2'd1, 8'd2);
        t1 = -1;
        t2 = -1;
        for (int i = 1; i <= 20; i++) begin
            idle(1);
            if (levelG == 8'd1 && t1 < 0) t1 = i;
            if (levelG == 8'd2) begin
                t2 = i;
                break;
            end
        end
        checkOutput("g reached within 8", (t2 >= 1 && t2 <= 8) ? 1 : 0, 1);
        checkOutput("g step spacing", t2 - t1, 4);

        $display("[TB] B ramp with mid-ramp retarget");
        stepDiv = 16'd0;
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        clearTrack();
        applyStimulus(1'b0, 1'b1, 2'd2, 8'd200);
        waitLevel(2, 50, 300);
        applyStimulus(1'b0, 1'b1, 2'd2, 8'd10);
        checkOutput("b step on retarget edge", int'(levelB), 51);
        waitLevel(2, 10, 300);
        idle(4);
        checkOutput("b final", int'(levelB), 10);
        checkOutput("b done pulses", trackDone[2], 1);
        checkOutput("b jumps", trackJump[2], 0);

        $display("[TB] R saturation at 255 and 0");
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        clearTrack();
        applyStimulus(1'b0, 1'b1, 2'd0, 8'd255);
        waitLevel(0, 255, 300);
        idle(5);
        checkOutput("r holds 255", int'(levelR), 255);
        checkOutput("r done at 255", trackDone[0], 1);
        clearTrack();
        applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
        waitLevel(0, 0, 300);
        idle(5);
        checkOutput("r holds 0", int'(levelR), 0);
        checkOutput("r done at 0", trackDone[0], 1);
        checkOutput("r jumps", trackJump[0], 0);
        clearTrack();
        applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
        idle(3);
        checkOutput("r no done on equal write", trackDone[0], 0);

        $display("[TB] channel 3 write");
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        clearTrack();
        applyStimulus(1'b0, 1'b1, 2'd3, 8'd7);
        idle(10);
`ifdef PWM_FADER_BROADCAST_EN
        checkOutput("bcast r", int'(levelR), 7);
        checkOutput("bcast g", int'(levelG), 7);
        checkOutput("bcast b", int'(levelB), 7);
        checkOutput("bcast done r", trackDone[0], 1);
        checkOutput("bcast done b", trackDone[2], 1);
        checkOutput("bcast err pulses", trackErr, 0);
`else
        checkOutput("chan3 err pulses", trackErr, 1);
        checkOutput("chan3 r unchanged", int'(levelR), 0);
        checkOutput("chan3 g unchanged", int'(levelG), 0);
        checkOutput("chan3 b unchanged", int'(levelB), 0);
        checkOutput("chan3 busy", int'(busy), 0);
`endif

        $display("[TB] reset mid-ramp with a pending write");
        applyStimulus(1'b0, 1'b1, 2'd0, 8'd100);
        idle(10);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'd77);
        checkOutput("rst level_r", int'(levelR), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst ready", int'(cfgBus.cfg_ready), 0);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        idle(5);
        checkOutput("rst write dropped g", int'(levelG), 0);
        checkOutput("rst targets cleared", int'(busy), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) stepDiv = 16'($urandom_range(0, 4));
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                applyStimulus(1'b1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                              8'($urandom_range(0, 255)));
            end else if (r < 12) begin
                applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            end else begin
                applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
